// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF->ID register with a two-entry skid buffer, flush/NOP insertion,
// sign-extended immediate and saturating flush/bubble counters.
module if_id_skid_stage #(
  parameter int                 PC_W     = 32,
  parameter int                 INST_W   = 32,
  parameter int                 IMM_W    = 16,
  parameter logic [INST_W-1:0]  NOP_INST = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [INST_W-1:0] out_imm,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t             state_q, state_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [INST_W-1:0]  main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic               accept, pop;
  assign in_ready   = state_q != FULL;
  assign out_valid  = state_q != EMPTY;
  assign out_pc     = main_pc_q;
  assign out_inst   = out_valid ? main_inst_q : NOP_INST;
  assign out_imm    = {{(INST_W-IMM_W){out_inst[IMM_W-1]}}, out_inst[IMM_W-1:0]};
  assign flush_cnt  = flush_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign accept     = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (flush) state_d = EMPTY;
    else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d     = ONE;
          main_pc_d   = in_pc;
          main_inst_d = in_inst;
        end
        ONE: if (accept & pop) begin
          main_pc_d   = in_pc;
          main_inst_d = in_inst;
        end else if (accept) begin
          state_d     = FULL;
          skid_pc_d   = in_pc;
          skid_inst_d = in_inst;
        end else if (pop) state_d = EMPTY;
        FULL: if (pop) begin
          state_d     = ONE;
          main_pc_d   = skid_pc_q;
          main_inst_d = skid_inst_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    // a flush only counts when it actually throws away a held or offered entry
    flush_cnt_d  = (flush && (out_valid || in_valid) && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    bubble_cnt_d = (!out_valid && out_ready && !(&bubble_cnt_q)) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_pc_q    <= '0;
      main_inst_q  <= NOP_INST;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_inst_q  <= main_inst_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
endmodule
